window_line_buffer: RTL and testbench
=====================================

// Module: window_line_buffer
// PURPOSE
//   Upstream neighbour of the convolution stage. Accepts a raster-order stream of DATA_WIDTH-bit pixels.
//   Emits every valid KERNEL_SIZE x KERNEL_SIZE window (no padding) as one flat bus in the same packing
//   the convolution stage indexes. Uses K-1 line buffers and a KxK window register; one window per accepted
//   pixel once the window is full.
// PARAMETERS
//   DATA_WIDTH   32   pixel width, bits (opaque; FP32 in practice, never interpreted here)
//   KERNEL_SIZE  3    window side K; legal range >= 2
//   IMG_WIDTH    224  pixels per row W; must be >= K
//   IMG_HEIGHT   224  rows per frame H; must be >= K
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-high
//   in_valid   in   1            in_pixel valid
//   in_ready   out  1            block can accept in_pixel this cycle
//   in_pixel   in   DATA_WIDTH   next raster-order pixel
//   out_valid  out  1            window valid
//   out_ready  in   1            downstream accepts window this cycle
//   window     out  K*K*DW       element i=r*K+c at [DATA_WIDTH*i +: DATA_WIDTH]; r=0 top row, c=0 left col
//   out_row    out  16           output-map row of window (0..H-K)
//   out_col    out  16           output-map col of window (0..W-K)
//   out_last   out  1            qualifies last window of frame (row H-K, col W-K)
// BEHAVIOUR
//   Reset (sync, reset=1 at clk edge): out_valid=0, out_last=0, window=0, out_row=out_col=0.
//     Input counters row=col=0. Line-buffer contents are not cleared (stale data is never emitted).
//   in_ready = !out_valid || out_ready (combinational; single output register, no skid).
//   Accept = in_valid && in_ready. Nothing changes on cycles without accept, except out_valid clearing on
//     out_valid && out_ready.
//   On accept of pixel at (row,col):
//     - Column vector v[r]: v[K-1]=in_pixel; v[r]=line buffer r at addr col, for r<K-1 (buffer 0 = oldest row).
//     - Line buffers shift at addr col: buf[r] <= buf[r+1], buf[K-2] <= in_pixel.
//       The read happens before the write in the same cycle.
//     - Window register shifts left one column and loads v as column K-1.
//     - col increments; at W-1 it wraps to 0 and row increments; at (H-1,W-1) both wrap to 0.
//       The next frame starts immediately; there is no gap.
//   Window emission: if accepted pixel has row>=K-1 && col>=K-1, next cycle out_valid=1 and window holds rows
//     row-K+1..row, cols col-K+1..col.
//     out_row=row-K+1, out_col=col-K+1, out_last=(row==H-1 && col==W-1). Latency: 1 cycle from accept.
//   Otherwise (window not yet full, incl. left-edge columns of each row) out_valid falls/stays 0 after handshake.
//   window/out_row/out_col/out_last hold stable while out_valid && !out_ready.
//   Column wrap: window contents spanning a row boundary are never emitted (col>=K-1 gate).
//   Reset mid-frame: the partial frame is discarded. The first pixel after reset is treated as (0,0).
//     No window is emitted until K-1 full rows have been re-fed.
//   Simultaneous out handshake and new accept: the new window (or out_valid=0) overwrites in the same edge.
//   Throughput: 1 pixel/cycle with out_ready held high.
// STRUCTURE
//   Shared package conv_pkg: DATA_WIDTH/KERNEL_SIZE defaults and the window-index function idx(r,c)=r*K+c.
//     The convolution stage uses the same function.
//   Sub-module line_buffer (depth IMG_WIDTH, width DATA_WIDTH, 1 read + 1 write, same address).
//     Instantiate K-1 of them in a generate loop.
//   Top level: counters, window shift register, output register, handshake logic.
// TESTING  (bench params: K=3, W=4, H=4, DW=32; pixel value = raster index 0..15)
//   1. Stream 0..15, out_ready=1. Expect exactly 4 windows: (0,0)={0,1,2,4,5,6,8,9,10}, (0,1) starts at 1,
//      (1,0) starts at 4, (1,1) starts at 5. Element 0 is in bits[31:0].
//      First window appears 1 cycle after pixel 10 is accepted; out_last=1 only on (1,1).
//   2. Backpressure: out_ready=0 after first window. Expect in_ready=0; window/out_row/out_col stable for
//      10 cycles. Release and expect no loss or duplication.
//   3. Bubbles: random in_valid gaps. Window values and order must be identical to test 1.
//   4. Back-to-back frames: 0..15 then 100..115 with no gap. Second frame first window = {100,101,102,104,105,106,108,109,110}.
//   5. Reset mid-frame: assert reset after pixel 9, then stream 200..215.
//      Expect no window before pixel 210; first window {200,201,202,204,205,206,208,209,210}.
//   6. Reset values: assert reset with out_valid=1. Next cycle out_valid=0, out_last=0, window=0, in_ready=1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the window line buffer and the convolution stage.
// Both blocks flatten a KxK window with the same idx() mapping, so changing it
// here changes it for both.
package conv_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int KERNEL_SIZE = 3;
    localparam int IMG_WIDTH   = 224;
    localparam int IMG_HEIGHT  = 224;
    localparam int COORD_W     = 16;

    // Flat window element index: r = 0 is the top row, c = 0 the left column.
    function automatic int idx(input int r, input int c, input int k = KERNEL_SIZE);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: one combinational read and one write per cycle at the
// same address. The read returns the value from before the write on that cycle.
// Contents are never cleared; the top level gates out windows holding stale rows.
module line_buffer #(
    parameter int DEPTH = 224,
    parameter int WIDTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Store the incoming pixel for this column; the old value has already been read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// Turns a raster-order pixel stream into every valid KxK window (no padding).
// K-1 line buffers supply the rows above the current pixel. A KxK shift register
// holds the window. One output register carries the window coordinates and valid.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_ready = !out_valid || out_ready, so input is accepted only when the output
// register is empty or is being drained on the same edge. A valid output holds
// window/out_row/out_col/out_last stable until it is taken.
module window_line_buffer #(
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int IMG_WIDTH   = conv_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT  = conv_pkg::IMG_HEIGHT
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_pixel,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
    output logic [15:0]                               out_row,
    output logic [15:0]                               out_col,
    output logic                                      out_last
);

    import conv_pkg::*;

    localparam int          K        = KERNEL_SIZE;
    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] KM1      = 16'(K - 1);

    logic [15:0]           row_q, row_d, col_q, col_d;
    logic [15:0]           out_row_q, out_row_d, out_col_q, out_col_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] win_q [K][K];
    logic [DATA_WIDTH-1:0] win_d [K][K];
    logic [DATA_WIDTH-1:0] col_vec [K];
    logic [DATA_WIDTH-1:0] lb_rd [K-1];
    logic [DATA_WIDTH-1:0] lb_wr [K-1];
    logic                  accept;
    logic                  win_full;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Window is complete only once K-1 rows are buffered and K columns of this row
    // are in; the column test also stops windows that straddle a row boundary.
    assign win_full = (row_q >= KM1) && (col_q >= KM1);

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (DATA_WIDTH)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col_q[AW-1:0]),
            .wr_data (lb_wr[g]),
            .rd_data (lb_rd[g])
        );
    end

    // Column vector (buffer 0 = oldest row = top) and the write-back that ages each row by one.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_vec[r] = lb_rd[r];
        end
        col_vec[K-1] = in_pixel;
        for (int r = 0; r < K - 2; r++) begin
            lb_wr[r] = lb_rd[r+1];
        end
        lb_wr[K-2] = in_pixel;
    end

    // Window register: shift left one column and load the new column at the right.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_vec[r];
            end
        end
    end

    // Raster counters and the output register with its handshake.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = 16'd0;
                row_d = (row_q == ROW_LAST) ? 16'd0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
            out_valid_d = win_full;
            out_last_d  = win_full && (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (win_full) begin
                out_row_d = row_q - KM1;
                out_col_d = col_q - KM1;
            end
        end
    end

    // State update; line buffer contents are left alone on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= 16'd0;
            col_q       <= 16'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= 16'd0;
            out_col_q   <= 16'd0;
            win_q       <= '{default: '0};
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            win_q       <= win_d;
        end
    end

    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            assign window[DATA_WIDTH*idx(gr, gc, K) +: DATA_WIDTH] = win_q[gr][gc];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer at K=3, W=4, H=4, DW=32.
module tb_window_line_buffer;

    localparam int DW = 32;
    localparam int K  = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = K * K * DW;
    localparam int RW = 1 + 16 + 16 + WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] window;
    logic [15:0]   out_row;
    logic [15:0]   out_col;
    logic          out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] obs_q[$];
    logic [DW-1:0] frame_v [W*H];

    always #5 clk = ~clk;

    window_line_buffer #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .window    (window),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    // Record every output transfer just before the edge that completes it.
    always begin
        @(negedge clk);
        #4;
        if (reset !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_q.push_back({out_last, out_row, out_col, window});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void fill_frame(input int base);
        for (int i = 0; i < W * H; i++) begin
            frame_v[i] = DW'(base + i);
        end
    endfunction

    // Reference: every KxK window of the frame, raster order, packed r*K+c.
    function automatic void model_frame();
        logic [WW-1:0] w;
        logic          last;
        for (int r = 0; r <= H - K; r++) begin
            for (int c = 0; c <= W - K; c++) begin
                w = '0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        w[DW*(i*K+j) +: DW] = frame_v[(r+i)*W + c + j];
                    end
                end
                last = (r == H - K) && (c == W - K);
                exp_q.push_back({last, 16'(r), 16'(c), w});
            end
        end
    endfunction

    task automatic step_idle(input bit rnd);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Present one pixel and return right after the edge that accepts it.
    task automatic drive_pixel(input logic [DW-1:0] v, input bit rnd);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = v;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        #1;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            $display("FAIL accept_timeout pixel=%0d in_ready=%b required=1", v, in_ready);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required=0", out_valid); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b required=0", out_last); else n_pass++;
        n_checks++; if (window !== '0) $display("FAIL reset_window got=%h required=0", window); else n_pass++;
        n_checks++; if (out_row !== 16'd0) $display("FAIL reset_out_row got=%0d required=0", out_row); else n_pass++;
        n_checks++; if (out_col !== 16'd0) $display("FAIL reset_out_col got=%0d required=0", out_col); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic exp_v;
        exp_q.delete(); obs_q.delete(); out_ready = 1'b1;
        fill_frame(0); model_frame();
        for (int i = 0; i < W * H; i++) begin
            drive_pixel(frame_v[i], 1'b0);
            #1;
            exp_v = ((i / W) >= K - 1) && ((i % W) >= K - 1);
            n_checks++;
            if (out_valid !== exp_v) $display("FAIL stream_latency pixel=%0d out_valid=%b required=%b", i, out_valid, exp_v);
            else n_pass++;
        end
        repeat (3) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL stream_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL stream_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete(); obs_q.delete(); out_ready = 1'b1;
        fill_frame(0); model_frame();
        for (int i = 0; i <= 10; i++) drive_pixel(frame_v[i], 1'b0);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_pixel = frame_v[11];
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_last, out_row, out_col, window} !== exp_q[0])
                $display("FAIL stall_hold[%0d] in_ready=%b out_valid=%b got=%h required in_ready=0 out_valid=1 %h",
                         k, in_ready, out_valid, {out_last, out_row, out_col, window}, exp_q[0]);
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 11; i < W * H; i++) drive_pixel(frame_v[i], 1'b0);
        repeat (3) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL stall_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL stall_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_bubbles();
        exp_q.delete(); obs_q.delete(); out_ready = 1'b1;
        fill_frame(0); model_frame();
        for (int i = 0; i < W * H; i++) begin
            repeat ($urandom_range(0, 3)) step_idle(1'b0);
            drive_pixel(frame_v[i], 1'b0);
        end
        repeat (3) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL bubble_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bubble_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); obs_q.delete(); out_ready = 1'b1;
        fill_frame(0); model_frame();
        for (int i = 0; i < W * H; i++) drive_pixel(frame_v[i], 1'b0);
        fill_frame(100); model_frame();
        for (int i = 0; i < W * H; i++) drive_pixel(frame_v[i], 1'b0);
        repeat (3) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        exp_q.delete(); obs_q.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W * H; i++) frame_v[i] = $urandom;
            model_frame();
            for (int i = 0; i < W * H; i++) begin
                repeat ($urandom_range(0, 2)) step_idle(1'b1);
                drive_pixel(frame_v[i], 1'b1);
            end
        end
        repeat (4) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL random_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL random_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        exp_q.delete(); obs_q.delete(); out_ready = 1'b1;
        fill_frame(0);
        for (int i = 0; i <= 9; i++) drive_pixel(frame_v[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fill_frame(200); model_frame();
        for (int i = 0; i < W * H; i++) begin
            drive_pixel(frame_v[i], 1'b0);
            #1;
            exp_v = ((i / W) >= K - 1) && ((i % W) >= K - 1);
            n_checks++;
            if (out_valid !== exp_v) $display("FAIL midreset_latency pixel=%0d out_valid=%b required=%b", 200 + i, out_valid, exp_v);
            else n_pass++;
        end
        repeat (3) step_idle(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL midreset_count got=%0d required=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL midreset_win[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_values();
        obs_q.delete(); out_ready = 1'b0;
        fill_frame(0);
        for (int i = 0; i <= 10; i++) drive_pixel(frame_v[i], 1'b0);
        #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rv_pre_valid got=%b required=1", out_valid); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rv_out_valid got=%b required=0", out_valid); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rv_out_last got=%b required=0", out_last); else n_pass++;
        n_checks++; if (window !== '0) $display("FAIL rv_window got=%h required=0", window); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rv_in_ready got=%b required=1", in_ready); else n_pass++;
        n_checks++; if (obs_q.size() != 0) $display("FAIL rv_no_transfer got=%0d required=0", obs_q.size()); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_reset_values();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
